// File: rtl/barrel_shifter_right_arithmetic_64.sv
// 64-bit arithmetic right barrel shifter, six-stage log mux, registered out.
// Ports: clk, rst_n (async low), data[63:0], _shift[63:0] (uses [5:0]), out[63:0].
module barrel_shifter_right_arithmetic_64 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] data,
  input  logic [63:0] _shift,
  output logic [63:0] out
);

  logic [5:0]  sh;
  logic        s;
  logic [63:0] st [0:6];
  logic        unused_hi;

  assign sh        = _shift[5:0];
  assign s         = data[63];
  assign unused_hi = ^_shift[63:6];
  assign st[0]     = data;

  // Each stage fills from the original sign bit, not the stage input MSB.
  for (genvar k = 0; k < 6; k++) begin : g_stage
    localparam int N = 1 << k;
    assign st[k+1] = sh[k]
      ? {{N{s}}, st[k][63:N]}
      : st[k];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out <= '0;
    else        out <= st[6];
  end

endmodule

// File: tb/tb_barrel_shifter_right_arithmetic_64.sv
// Directed self-checking bench for barrel_shifter_right_arithmetic_64.
// Vectors applied on negedge, result sampled 1 ns after the next posedge.
module tb_barrel_shifter_right_arithmetic_64;

  logic        clk;
  logic        rst_n;
  logic [63:0] data;
  logic [63:0] _shift;
  logic [63:0] out;

  int tests;
  int fails;

  barrel_shifter_right_arithmetic_64 dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .data   (data),
    ._shift (_shift),
    .out    (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] exp);
    tests++;
    assert (out === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, out, exp);
    end
  endtask

  task automatic apply(input string tag, input logic [63:0] d,
                       input logic [63:0] sa, input logic [63:0] exp);
    @(negedge clk);
    data   = d;
    _shift = sa;
    @(posedge clk);
    #1;
    check(tag, exp);
  endtask

  initial begin
    tests  = 0;
    fails  = 0;
    rst_n  = 1'b0;
    data   = 64'h8000_0000_0000_0000;
    _shift = 64'd1;
    #1;
    check("reset_init", 64'h0);
    @(posedge clk);
    #1;
    check("reset_held", 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    apply("sign_sh0", 64'h8000_0000_0000_0000, 64'd0,
          64'h8000_0000_0000_0000);
    apply("sign_sh1", 64'h8000_0000_0000_0000, 64'd1,
          64'hC000_0000_0000_0000);
    apply("sign_sh4", 64'h8000_0000_0000_0000, 64'd4,
          64'hF800_0000_0000_0000);
    apply("multi_sh13", 64'h8000_0000_0000_0000, 64'd13,
          64'hFFFC_0000_0000_0000);
    apply("multi_sh32", 64'h8000_0000_0000_0000, 64'd32,
          64'hFFFF_FFFF_8000_0000);
    apply("multi_sh36", 64'h8000_0000_0000_0000, 64'd36,
          64'hFFFF_FFFF_F800_0000);
    apply("multi_sh63", 64'h8000_0000_0000_0000, 64'd63,
          64'hFFFF_FFFF_FFFF_FFFF);
    apply("mask_sh65", 64'h8000_0000_0000_0000, 64'd65,
          64'hC000_0000_0000_0000);
    apply("mask_hi", 64'h8000_0000_0000_0000,
          64'hFFFF_FFFF_FFFF_FFC0, 64'h8000_0000_0000_0000);
    apply("pos_one", 64'h0000_0000_0000_0001, 64'd1, 64'h0);
    apply("pos_max63", 64'h7FFF_FFFF_FFFF_FFFF, 64'd63, 64'h0);
    apply("pos_sh8", 64'h0123_4567_89AB_CDEF, 64'd8,
          64'h0001_2345_6789_ABCD);
    apply("pattern", 64'hA0A0_A0A0_A0A0_A0A0, 64'd4,
          64'hFA0A_0A0A_0A0A_0A0A);
    apply("neg_sh16", 64'hFEDC_BA98_7654_3210, 64'd16,
          64'hFFFF_FEDC_BA98_7654);

    // Inputs moving between edges must not reach out.
    data   = 64'h0000_0000_0000_0100;
    _shift = 64'd2;
    #3;
    check("hold_between", 64'hFFFF_FEDC_BA98_7654);
    @(posedge clk);
    #1;
    check("after_change", 64'h0000_0000_0000_0040);

    // Mid-stream reset between edges.
    @(negedge clk);
    data   = 64'h8000_0000_0000_0000;
    _shift = 64'd1;
    rst_n  = 1'b0;
    #1;
    check("rst_async", 64'h0);
    @(posedge clk);
    #1;
    check("rst_hold", 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_release", 64'h0);
    @(posedge clk);
    #1;
    check("rst_first", 64'hC000_0000_0000_0000);

    // Back-to-back, new inputs every cycle.
    apply("b2b_0", 64'hF000_0000_0000_0000, 64'd60, 64'hFFFF_FFFF_FFFF_FFFF);
    apply("b2b_1", 64'h4000_0000_0000_0000, 64'd62, 64'h1);
    apply("b2b_2", 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF);
    apply("b2b_3", 64'h1234_0000_0000_0000, 64'd48, 64'h1234);
    apply("b2b_4", 64'h8765_4321_0000_0000, 64'd32,
          64'hFFFF_FFFF_8765_4321);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
